chacha_sequencer: RTL and testbench
===================================

# chacha_sequencer

Block sequencer for the `chacha` keystream core. Holds a host-written key, nonce and 64-bit block counter in local registers. On command it generates N consecutive keystream blocks by resetting the core, streaming the 48 load bytes into it, waiting for `blk_ready`, and draining the 64 output bytes to a valid-only keystream port. The 64-bit block counter advances after each block.

## Interface
- `MAX_BLK_W`, default 8: width of the block-count command field.
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-high reset.
- `cfg_we` in 1: config byte write strobe.
- `cfg_addr` in 6: byte address; 0–31 key, 32–39 nonce, 40–47 counter (LSB at 40); 48–63 ignored.
- `cfg_data` in 8: config write data.
- `start` in 1: begin a run, sampled in IDLE only.
- `nblk` in MAX_BLK_W: number of blocks, sampled with `start`; 0 means 2^MAX_BLK_W.
- `abort` in 1: terminate the run.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse after the last byte of the last block, or after an abort.
- `ks_valid` out 1: keystream byte valid. There is no backpressure, so the sink must accept every byte.
- `ks_data` out 8: keystream byte.
- `ks_last` out 1: marks byte 63 of each block.
- `core_rst_n` out 1: core reset, active low.
- `core_wr_key`, `core_wr_nnc`, `core_wr_ctr`, `core_rd_blk`, `core_hold` out 1 each: core controls.
- `core_din` out 8: core `data_in`.
- `core_blk_ready` in 1: core `blk_ready`.
- `core_dout` in 8: core `data_out`.

## Operation
- Register file: 48 bytes. `cfg_we` writes are accepted only while `busy` is low and are silently dropped while busy.
- States and transitions:
  - IDLE → CRST on `start`. The sequencer latches `nblk` into `remaining`.
  - CRST: 1 cycle with `core_rst_n`=0 → LD_KEY. The core is re-reset before every block because its round count is not self-clearing.
  - LD_KEY: 32 cycles, `core_din` = key[i] for i = 0..31. `core_wr_key`=1 on the first cycle only.
  - LD_NNC: 8 cycles, nonce[0..7]. `core_wr_nnc` on the first cycle.
  - LD_CTR: 8 cycles, counter bytes LSB first. `core_wr_ctr` on the first cycle.
  - The three load phases are back to back with no gap cycles. `core_hold`=1 from CRST through the end of LD_CTR, and 0 otherwise.
  - LD_CTR → WAIT. WAIT → READ when `core_blk_ready`=1.
  - READ: 64 cycles. `core_rd_blk`=1 on the first cycle only. The core presents byte k combinationally during read cycle k. The sequencer registers it onto `ks_data` with `ks_valid`=1, and sets `ks_last` for k=63.
  - READ → NEXT: counter ← counter+1 (mod 2^64, wraps to 0) and `remaining` ← `remaining`−1. Then:
    - if the new `remaining` is nonzero, go to CRST;
    - otherwise pulse `done` and go to IDLE.
- Abort: `abort` in any non-IDLE state goes to IDLE on the next edge.
  - `core_rst_n` is driven low for that cycle.
  - `done` pulses.
  - The counter keeps the value it last advanced to.
  - Bytes already emitted stand, and no further `ks_valid` is produced.
  - `abort` in IDLE has no effect.
- Simultaneous events:
  - `start` and `abort` in IDLE: `start` wins.
  - `cfg_we` in the same cycle as an accepted `start`: the write takes effect and is used by the run.

## Timing
- Reset values:
  - state IDLE, `busy` 0, `done` 0;
  - `ks_valid` 0, `ks_data` 0, `ks_last` 0;
  - `core_rst_n` 0 during `rst`, 1 after;
  - all other core controls 0, `core_din` 0;
  - register file all zero.
- Start to first core write: `start` in cycle t → CRST at t+1 → `core_wr_key` at t+2.
- Load phase: 48 cycles.
- Per-block overhead excluding core compute: 1 + 48 + 64 + 1 = 114 cycles, plus the WAIT duration.
- Keystream latency: byte k of a block has `ks_valid` one cycle after read cycle k. The 64 bytes are contiguous.
- `done` is asserted in the cycle after NEXT (normal completion) or in the cycle after `abort` is sampled.

## Structure
- A shared package `chacha_pkg` holds:
  - the state enum;
  - the address-map constants: KEY_BASE=0, NNC_BASE=32, CTR_BASE=40, CFG_BYTES=48;
  - the phase lengths: 32, 8, 8, 64.
- One sub-module, `chacha_cfg_regs`: the 48-byte register file with a host write port, a sequencer read port (byte index → byte), and the counter increment/load port.
- The FSM, byte index counter and `remaining` counter live in `chacha_sequencer`.

## Test plan
- Load the RFC 8439-style all-zero key, nonce and counter; `start` with `nblk`=1 → core sees 48 load bytes in order, 64 `ks_valid` bytes arrive, `ks_last` on the 64th, one `done`, counter register = 1.
- Set counter = 0xFFFF_FFFF_FFFF_FFFF and `nblk`=2 → second block is loaded with counter 0, and counter ends at 1.
- `nblk`=3 with a core model whose `blk_ready` delay is randomized per block → exactly 192 `ks_valid` cycles, `core_rst_n` pulses low 3 times, one `done`.
- Assert `abort` midway through READ of block 1 of 2 → `ks_valid` stops the next cycle, `done` pulses, `busy` drops, counter unchanged from its pre-block value.
- `cfg_we` to key byte 5 while busy → register unchanged, and the next run loads the old value.
- Assert `rst` asynchronously during LD_NNC → all outputs at reset values immediately, FSM in IDLE after release.

Source files
------------

// File: rtl/chacha_pkg.sv
// Shared definitions for the chacha block sequencer: FSM states, the
// configuration address map and the length of each load/read phase.
package chacha_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CRST   = 3'd1,
    ST_LD_KEY = 3'd2,
    ST_LD_NNC = 3'd3,
    ST_LD_CTR = 3'd4,
    ST_WAIT   = 3'd5,
    ST_READ   = 3'd6,
    ST_NEXT   = 3'd7
  } state_e;

  localparam int unsigned KEY_BASE  = 0;
  localparam int unsigned NNC_BASE  = 32;
  localparam int unsigned CTR_BASE  = 40;
  localparam int unsigned CFG_BYTES = 48;

  localparam int unsigned KEY_LEN = 32;
  localparam int unsigned NNC_LEN = 8;
  localparam int unsigned CTR_LEN = 8;
  localparam int unsigned BLK_LEN = 64;

  // Register-file byte address feeding the core during a load phase.
  function automatic logic [5:0] load_addr(input state_e st, input logic [5:0] idx);
    logic [5:0] a;
    case (st)
      ST_LD_KEY: a = 6'(KEY_BASE) + idx;
      ST_LD_NNC: a = 6'(NNC_BASE) + idx;
      ST_LD_CTR: a = 6'(CTR_BASE) + idx;
      default:   a = 6'd0;
    endcase
    return a;
  endfunction

  function automatic logic is_load(input state_e st);
    logic r;
    case (st)
      ST_CRST, ST_LD_KEY, ST_LD_NNC, ST_LD_CTR: r = 1'b1;
      default:                                  r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/chacha_cfg_regs.sv
// 48-byte key/nonce/counter register file with a host write port, a byte
// read port for the sequencer and an in-place 64-bit counter increment.
module chacha_cfg_regs
  import chacha_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [5:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [5:0] rd_addr,
  output logic [7:0] rd_data,
  input  logic       ctr_inc
);

  logic [7:0]  mem_q [CFG_BYTES];
  logic [7:0]  mem_d [CFG_BYTES];
  logic [63:0] ctr_s;
  logic [63:0] ctr_next_s;

  // Counter view (LSB at CTR_BASE), its successor and the next register image.
  always_comb begin
    ctr_s = 64'd0;
    for (int i = 0; i < 8; i++) begin
      ctr_s[i*8 +: 8] = mem_q[CTR_BASE + i];
    end
    ctr_next_s = ctr_s + 64'd1;
    for (int i = 0; i < CFG_BYTES; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (ctr_inc) begin
      for (int i = 0; i < 8; i++) begin
        mem_d[CTR_BASE + i] = ctr_next_s[i*8 +: 8];
      end
    end else if (wr_en && (wr_addr < 6'(CFG_BYTES))) begin
      mem_d[wr_addr] = wr_data;
    end else begin
      mem_d[0] = mem_q[0];
    end
  end

  // Register file storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CFG_BYTES; i++) begin
        mem_q[i] <= 8'd0;
      end
    end else begin
      for (int i = 0; i < CFG_BYTES; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Sequencer read port; out-of-map addresses read as zero.
  always_comb begin
    if (rd_addr < 6'(CFG_BYTES)) begin
      rd_data = mem_q[rd_addr];
    end else begin
      rd_data = 8'd0;
    end
  end

endmodule

// File: rtl/chacha_sequencer.sv
// Block sequencer for the chacha keystream core: reloads the core before each
// block, waits for it, and drains 64 keystream bytes per block.
module chacha_sequencer
  import chacha_pkg::*;
#(
  parameter int MAX_BLK_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_we,
  input  logic [5:0]           cfg_addr,
  input  logic [7:0]           cfg_data,
  input  logic                 start,
  input  logic [MAX_BLK_W-1:0] nblk,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic                 ks_valid,
  output logic [7:0]           ks_data,
  output logic                 ks_last,
  output logic                 core_rst_n,
  output logic                 core_wr_key,
  output logic                 core_wr_nnc,
  output logic                 core_wr_ctr,
  output logic                 core_rd_blk,
  output logic                 core_hold,
  output logic [7:0]           core_din,
  input  logic                 core_blk_ready,
  input  logic [7:0]           core_dout
);

  state_e               state_q, state_d;
  logic [5:0]           idx_q, idx_d;
  logic [MAX_BLK_W:0]   rem_q, rem_d;
  logic                 abort_hit_s;
  logic                 ctr_inc_s;
  logic                 cfg_wr_s;
  logic [5:0]           rd_addr_s;
  logic [7:0]           rd_data_s;

  logic                 busy_q, busy_d, done_q, done_d;
  logic                 ks_valid_q, ks_valid_d, ks_last_q, ks_last_d;
  logic [7:0]           ks_data_q, ks_data_d, core_din_q, core_din_d;
  logic                 core_rst_n_q, core_rst_n_d, core_hold_q, core_hold_d;
  logic                 core_wr_key_q, core_wr_key_d, core_wr_nnc_q, core_wr_nnc_d;
  logic                 core_wr_ctr_q, core_wr_ctr_d, core_rd_blk_q, core_rd_blk_d;

  assign cfg_wr_s  = cfg_we && (state_q == ST_IDLE);
  assign rd_addr_s = load_addr(state_d, idx_d);

  chacha_cfg_regs u_regs (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (cfg_wr_s),
    .wr_addr (cfg_addr),
    .wr_data (cfg_data),
    .rd_addr (rd_addr_s),
    .rd_data (rd_data_s),
    .ctr_inc (ctr_inc_s)
  );

  // FSM state, phase byte index and blocks-remaining counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= 6'd0;
      rem_q   <= {(MAX_BLK_W+1){1'b0}};
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
    end
  end

  // Next-state logic; abort overrides everything outside IDLE.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rem_d       = rem_q;
    abort_hit_s = 1'b0;
    ctr_inc_s   = 1'b0;
    if (abort && (state_q != ST_IDLE)) begin
      state_d     = ST_IDLE;
      idx_d       = 6'd0;
      abort_hit_s = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_CRST;
            idx_d   = 6'd0;
            rem_d   = (nblk == {MAX_BLK_W{1'b0}}) ? {1'b1, {MAX_BLK_W{1'b0}}} : {1'b0, nblk};
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_CRST: begin
          state_d = ST_LD_KEY;
          idx_d   = 6'd0;
        end
        ST_LD_KEY: begin
          if (idx_q == 6'(KEY_LEN - 1)) begin
            state_d = ST_LD_NNC;
            idx_d   = 6'd0;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
        ST_LD_NNC: begin
          if (idx_q == 6'(NNC_LEN - 1)) begin
            state_d = ST_LD_CTR;
            idx_d   = 6'd0;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
        ST_LD_CTR: begin
          if (idx_q == 6'(CTR_LEN - 1)) begin
            state_d = ST_WAIT;
            idx_d   = 6'd0;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
        ST_WAIT: begin
          if (core_blk_ready) begin
            state_d = ST_READ;
            idx_d   = 6'd0;
          end else begin
            state_d = ST_WAIT;
          end
        end
        ST_READ: begin
          if (idx_q == 6'(BLK_LEN - 1)) begin
            state_d   = ST_NEXT;
            idx_d     = 6'd0;
            ctr_inc_s = 1'b1;
            rem_d     = rem_q - (MAX_BLK_W+1)'(1);
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
        ST_NEXT: begin
          if (rem_q != {(MAX_BLK_W+1){1'b0}}) begin
            state_d = ST_CRST;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          idx_d   = 6'd0;
        end
      endcase
    end
  end

  // Output decode: every output is registered from the state being entered.
  always_comb begin
    busy_d        = (state_d != ST_IDLE);
    done_d        = abort_hit_s || ((state_q == ST_NEXT) && (state_d == ST_IDLE));
    core_rst_n_d  = !((state_d == ST_CRST) || abort_hit_s);
    core_hold_d   = is_load(state_d);
    core_wr_key_d = (state_d == ST_LD_KEY) && (idx_d == 6'd0);
    core_wr_nnc_d = (state_d == ST_LD_NNC) && (idx_d == 6'd0);
    core_wr_ctr_d = (state_d == ST_LD_CTR) && (idx_d == 6'd0);
    core_rd_blk_d = (state_d == ST_READ) && (idx_d == 6'd0);
    core_din_d    = 8'd0;
    ks_valid_d    = 1'b0;
    ks_data_d     = 8'd0;
    ks_last_d     = 1'b0;
    if (is_load(state_d) && (state_d != ST_CRST)) begin
      core_din_d = rd_data_s;
    end else begin
      core_din_d = 8'd0;
    end
    if ((state_q == ST_READ) && !abort_hit_s) begin
      ks_valid_d = 1'b1;
      ks_data_d  = core_dout;
      ks_last_d  = (idx_q == 6'(BLK_LEN - 1));
    end else begin
      ks_valid_d = 1'b0;
    end
  end

  // Output registers; the core is held in reset while rst is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      ks_valid_q    <= 1'b0;
      ks_data_q     <= 8'd0;
      ks_last_q     <= 1'b0;
      core_rst_n_q  <= 1'b0;
      core_hold_q   <= 1'b0;
      core_wr_key_q <= 1'b0;
      core_wr_nnc_q <= 1'b0;
      core_wr_ctr_q <= 1'b0;
      core_rd_blk_q <= 1'b0;
      core_din_q    <= 8'd0;
    end else begin
      busy_q        <= busy_d;
      done_q        <= done_d;
      ks_valid_q    <= ks_valid_d;
      ks_data_q     <= ks_data_d;
      ks_last_q     <= ks_last_d;
      core_rst_n_q  <= core_rst_n_d;
      core_hold_q   <= core_hold_d;
      core_wr_key_q <= core_wr_key_d;
      core_wr_nnc_q <= core_wr_nnc_d;
      core_wr_ctr_q <= core_wr_ctr_d;
      core_rd_blk_q <= core_rd_blk_d;
      core_din_q    <= core_din_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign ks_valid    = ks_valid_q;
  assign ks_data     = ks_data_q;
  assign ks_last     = ks_last_q;
  assign core_rst_n  = core_rst_n_q;
  assign core_hold   = core_hold_q;
  assign core_wr_key = core_wr_key_q;
  assign core_wr_nnc = core_wr_nnc_q;
  assign core_wr_ctr = core_wr_ctr_q;
  assign core_rd_blk = core_rd_blk_q;
  assign core_din    = core_din_q;

endmodule

// File: tb/tb_chacha_sequencer.sv
// Randomized self-checking bench for chacha_sequencer with a behavioural core
// model and a keystream scoreboard derived from the host register image.
module tb_chacha_sequencer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         cfg_we;
  logic [5:0]   cfg_addr;
  logic [7:0]   cfg_data;
  logic         start;
  logic [W-1:0] nblk;
  logic         abort;
  logic         busy, done, ks_valid, ks_last;
  logic [7:0]   ks_data;
  logic         core_rst_n, core_wr_key, core_wr_nnc, core_wr_ctr, core_rd_blk, core_hold;
  logic [7:0]   core_din;
  logic         core_blk_ready;
  logic [7:0]   core_dout;

  always #5 clk = ~clk;

  chacha_sequencer #(.MAX_BLK_W(W)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .start(start), .nblk(nblk), .abort(abort), .busy(busy), .done(done),
    .ks_valid(ks_valid), .ks_data(ks_data), .ks_last(ks_last),
    .core_rst_n(core_rst_n), .core_wr_key(core_wr_key), .core_wr_nnc(core_wr_nnc),
    .core_wr_ctr(core_wr_ctr), .core_rd_blk(core_rd_blk), .core_hold(core_hold),
    .core_din(core_din), .core_blk_ready(core_blk_ready), .core_dout(core_dout)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Host-side image of the 48 configuration bytes.
  logic [7:0] ref_cfg [48];

  function automatic logic [63:0] ref_ctr();
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = ref_cfg[40 + i];
    return r;
  endfunction

  // Fake keystream: byte k repeats load byte k%48, whitened by k.
  function automatic logic [7:0] ks_fn(input logic [7:0] ld, input int k);
    return ld ^ 8'(k * 37 + 1);
  endfunction

  function automatic logic [7:0] exp_byte(input logic [63:0] c, input int k);
    int j;
    logic [7:0] v;
    j = k % 48;
    if (j >= 40) v = c[(j - 40) * 8 +: 8];
    else         v = ref_cfg[j];
    return ks_fn(v, k);
  endfunction

  // Core model: captures the 48-byte load, raises blk_ready after a random
  // delay, then presents one keystream byte per read cycle.
  logic [7:0] load_mem [48];
  int lc = -1;
  int rd_k = -1;
  int ready_cnt = -1;

  always @(negedge clk) begin
    if (rst || !core_rst_n) begin
      lc = -1; rd_k = -1; ready_cnt = -1;
      core_blk_ready = 1'b0;
      core_dout = 8'd0;
    end else begin
      if (core_wr_key) lc = 0;
      if (lc >= 0 && lc < 48) begin
        check_eq("ld_strobes", {core_wr_key, core_wr_nnc, core_wr_ctr, core_hold},
                 {lc == 0, lc == 32, lc == 40, 1'b1});
        load_mem[lc] = core_din;
        lc++;
        if (lc == 48) ready_cnt = $urandom_range(1, 6);
      end else if (ready_cnt > 0) begin
        ready_cnt--;
        if (ready_cnt == 0) core_blk_ready = 1'b1;
      end
      if (core_rd_blk) begin
        rd_k = 0;
        core_blk_ready = 1'b0;
      end else if (rd_k >= 0 && rd_k < 64) begin
        rd_k++;
      end
      core_dout = (rd_k >= 0 && rd_k < 64) ? ks_fn(load_mem[rd_k % 48], rd_k) : 8'd0;
    end
  end

  // Keystream scoreboard and event counters.
  logic [7:0] exp_q [$];
  int n_valid, n_done, n_rstlow, pos;

  always @(negedge clk) begin
    if (!rst) begin
      if (ks_valid) begin
        check_eq("ks_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) check_eq("ks_data", ks_data, exp_q.pop_front());
        check_eq("ks_last", ks_last, pos == 63);
        pos = (pos + 1) % 64;
        n_valid++;
      end
      if (done) n_done++;
      if (!core_rst_n) n_rstlow++;
    end
  end

  task automatic cfg_write(input int addr, input logic [7:0] data);
    @(negedge clk); #1;
    cfg_we = 1'b1; cfg_addr = 6'(addr); cfg_data = data;
    @(negedge clk); #1;
    cfg_we = 1'b0;
    if (addr < 48) ref_cfg[addr] = data;
  endtask

  task automatic set_ctr(input logic [63:0] c);
    for (int i = 0; i < 8; i++) cfg_write(40 + i, c[i*8 +: 8]);
  endtask

  task automatic run(input int n, input int abort_at, input bit busy_wr,
                     input bit wr_start, input bit start_abort);
    logic [63:0] c;
    int budget;
    bit aborted;
    int wa;
    logic [7:0] wd;
    @(negedge clk); #1;
    if (wr_start) begin
      wa = $urandom_range(0, 47);
      wd = 8'($urandom);
      cfg_we = 1'b1; cfg_addr = 6'(wa); cfg_data = wd;
      ref_cfg[wa] = wd;
    end
    c = ref_ctr();
    for (int b = 0; b < n; b++) begin
      for (int k = 0; k < 64; k++) exp_q.push_back(exp_byte(c, k));
      c = c + 64'd1;
    end
    n_valid = 0; n_done = 0; n_rstlow = 0; pos = 0;
    start = 1'b1; nblk = W'(n); abort = start_abort;
    @(negedge clk); #1;
    start = 1'b0; abort = 1'b0; cfg_we = 1'b0;
    check_eq("crst_state", {busy, core_rst_n, core_hold}, 3'b101);
    @(negedge clk); #1;
    check_eq("first_wr_key", core_wr_key, 1'b1);
    budget = 0; aborted = 0;
    while (budget < 5000) begin
      @(negedge clk); #1;
      budget++;
      if (abort) begin
        abort = 1'b0;
        check_eq("abort_outputs", {ks_valid, busy, core_rst_n}, 3'b000);
      end
      if (done) break;
      if (busy_wr && budget == 20) begin
        cfg_we = 1'b1; cfg_addr = 6'd5; cfg_data = ~ref_cfg[5];
      end else begin
        cfg_we = 1'b0;
      end
      if (abort_at >= 0 && !aborted && n_valid == abort_at) begin
        abort = 1'b1; aborted = 1;
      end
    end
    cfg_we = 1'b0;
    check_eq("done_seen", done, 1'b1);
    @(negedge clk); #1;
    check_eq("done_pulse_idle", {done, busy}, 2'b00);
    check_eq("done_count", n_done, 1);
    if (abort_at < 0) begin
      check_eq("ks_count", n_valid, 64 * n);
      check_eq("crst_count", n_rstlow, n);
      check_eq("exp_drained", exp_q.size(), 0);
      set_ref_ctr(ref_ctr() + 64'(n));
    end else begin
      check_eq("abort_ks_count", n_valid, abort_at);
      check_eq("abort_rst_count", n_rstlow, 2);
      exp_q.delete();
    end
  endtask

  task automatic set_ref_ctr(input logic [63:0] c);
    for (int i = 0; i < 8; i++) ref_cfg[40 + i] = c[i*8 +: 8];
  endtask

  initial begin
    int budget;
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = 6'd0; cfg_data = 8'd0;
    start = 1'b0; nblk = '0; abort = 1'b0;
    for (int i = 0; i < 48; i++) ref_cfg[i] = 8'd0;
    #23;
    check_eq("reset_outputs",
             {busy, done, ks_valid, ks_last, core_rst_n, core_wr_key, core_wr_nnc,
              core_wr_ctr, core_rd_blk, core_hold, ks_data, core_din}, 26'd0);
    @(negedge clk); #1 rst = 1'b0;
    @(negedge clk); #1;
    check_eq("post_reset_core_rst_n", {core_rst_n, busy}, 2'b10);

    // Abort in IDLE must be ignored.
    abort = 1'b1;
    @(negedge clk); #1 abort = 1'b0;
    check_eq("idle_abort_ignored", {busy, done}, 2'b00);

    run(1, -1, 0, 0, 0);                      // all-zero configuration
    set_ctr(64'hFFFF_FFFF_FFFF_FFFF);
    run(2, -1, 0, 0, 0);                      // counter wraps to 0 on block 2
    run(3, -1, 0, 0, 0);                      // random core latency per block
    for (int i = 0; i < 48; i++) cfg_write(i, 8'($urandom));
    run(1, -1, 0, 1, 1);                      // write with start; start beats abort
    run(2, 20, 0, 0, 0);                      // abort inside first READ
    run(1, -1, 1, 0, 0);                      // write while busy is dropped
    run(2, -1, 0, 0, 0);

    // Asynchronous reset while loading the nonce.
    @(negedge clk); #1 start = 1'b1; nblk = W'(1);
    @(negedge clk); #1 start = 1'b0;
    budget = 0;
    while (!(lc >= 34 && lc <= 38) && budget < 200) begin
      @(negedge clk); #1 budget++;
    end
    check_eq("reach_ld_nnc", (lc >= 34 && lc <= 38), 1'b1);
    #2 rst = 1'b1;
    #1;
    check_eq("async_reset_outputs",
             {busy, done, ks_valid, ks_last, core_rst_n, core_wr_key, core_wr_nnc,
              core_wr_ctr, core_rd_blk, core_hold, ks_data, core_din}, 26'd0);
    @(negedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 48; i++) ref_cfg[i] = 8'd0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    #1;
    check_eq("idle_after_reset", {busy, core_rst_n, core_hold}, 3'b010);
    run(1, -1, 0, 0, 0);                      // register file cleared by reset

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
